// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: pipeline control, instruction-ROM port and IF/ID outputs.
interface inst_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            flush;
  logic [XLEN-1:0] new_pc;
  logic            branch_flag;
  logic [XLEN-1:0] branch_target;
  logic            rom_ce;
  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_data;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic            id_valid;
  logic            id_adel;
  logic [XLEN-1:0] fetch_cnt;

  // Environment side: pipeline control and ROM model drive the fetch stage.
  modport master (
    output stall, flush, new_pc, branch_flag, branch_target, rom_data,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel, fetch_cnt
  );

  // Fetch stage side.
  modport slave (
    input  stall, flush, new_pc, branch_flag, branch_target, rom_data,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel, fetch_cnt
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, ROM addressing and the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.slave bus
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] r_pc;
  logic            r_ce_q;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_inst;
  logic            r_id_valid;
  logic            r_id_adel;
  logic [XLEN-1:0] r_fetch_cnt;

  logic            w_misaligned;
  logic            w_fetch_adel;
  logic [XLEN-1:0] w_pc_seq;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_fetch_adel = r_ce_q & w_misaligned;
  assign w_pc_seq     = r_pc + XLEN'(4);

  // ROM is addressed straight from the PC; a misaligned PC never enables it.
  assign bus.rom_addr  = r_pc;
  assign bus.rom_ce    = w_misaligned ? 1'b0 : r_ce_q;

  assign bus.id_pc     = r_id_pc;
  assign bus.id_inst   = r_id_inst;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_adel   = r_id_adel;
  assign bus.fetch_cnt = r_fetch_cnt;

  // PC and fetch enable: flush > stall > branch > sequential, frozen while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_ce_q <= 1'b0;
    end else begin
      r_ce_q <= 1'b1;
      if (r_ce_q) begin
        if (bus.flush) begin
          r_pc <= bus.new_pc;
        end else if (bus.stall) begin
          r_pc <= r_pc;
        end else if (bus.branch_flag) begin
          r_pc <= bus.branch_target;
        end else begin
          r_pc <= w_pc_seq;
        end
      end
    end
  end

  // IF/ID register: flush bubbles, stall holds, otherwise capture (branch keeps the delay slot).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc     <= '0;
      r_id_inst   <= '0;
      r_id_valid  <= 1'b0;
      r_id_adel   <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (bus.flush) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
      r_id_adel  <= 1'b0;
    end else if (!bus.stall) begin
      r_id_pc    <= r_pc;
      r_id_inst  <= w_fetch_adel ? '0 : bus.rom_data;
      r_id_valid <= r_ce_q;
      r_id_adel  <= w_fetch_adel;
      if (r_ce_q) begin
        r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
      end
    end
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded by reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-004 SHALL have port stall, input, 1, meaning a pipeline-control request to hold PC and the IF/ID register.
REQ-005 SHALL have port flush, input, 1, meaning an exception or eret redirect request.
REQ-006 SHALL have port new_pc, input, 32, meaning the redirect target (handler entry or EPC), valid with flush.
REQ-007 SHALL have port branch_flag, input, 1, meaning ID resolved a taken branch or jump.
REQ-008 SHALL have port branch_target, input, 32, meaning the taken-branch target, valid with branch_flag.
REQ-009 SHALL have port rom_ce, output, 1, meaning the instruction-ROM chip enable (1 = enabled).
REQ-010 SHALL have port rom_addr, output, 32, meaning the ROM byte address; the ROM indexes by addr[11:2].
REQ-011 SHALL have port rom_data, input, 32, meaning the ROM read data, combinational on rom_addr; 0 while rom_ce = 0.
REQ-012 SHALL have port id_pc, output, 32, meaning the PC of the instruction held in IF/ID.
REQ-013 SHALL have port id_inst, output, 32, meaning the instruction held in IF/ID.
REQ-014 SHALL have port id_valid, output, 1, meaning IF/ID holds a real fetch rather than a bubble.
REQ-015 SHALL have port id_adel, output, 1, meaning the IF/ID entry came from a misaligned fetch (AdEL).
REQ-016 SHALL have port fetch_cnt, output, 32, meaning the count of instructions delivered to ID.

Function
REQ-017 SHALL hold a PC register pc; rom_addr SHALL equal pc combinationally.
REQ-018 SHALL drive rom_ce = 0 when pc[1:0] != 0, and otherwise drive it from the registered enable ce_q.
REQ-019 SHALL set ce_q to 0 during reset and to 1 on every cycle thereafter.
REQ-020 SHALL update pc in cycles where ce_q = 1, using the priority flush > stall > branch_flag > sequential.
REQ-021 SHALL load pc <= new_pc on flush.
REQ-022 SHALL hold pc unchanged on stall.
REQ-023 SHALL load pc <= branch_target on branch_flag.
REQ-024 SHALL otherwise load pc <= pc + 4, with the addition wrapping modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-025 SHALL not advance pc in the cycle where ce_q = 0.
REQ-026 SHALL update the IF/ID register on the edge with the same priority as pc.
REQ-027 SHALL, on flush, set id_inst = 0, id_pc = 0, id_valid = 0 and id_adel = 0.
REQ-028 SHALL, on stall, hold id_inst, id_pc, id_valid and id_adel.
REQ-029 SHALL, otherwise, set id_pc = pc, id_inst = rom_data, id_valid = ce_q and id_adel = ce_q & (pc[1:0] != 0).
REQ-030 SHALL force id_inst to 0 whenever id_adel = 1.
REQ-031 SHALL treat branch_flag as not redirecting IF/ID: the instruction at pc is fetched as the delay slot and captured normally.
REQ-032 SHALL ignore branch_flag while stall = 1, because ID holds it and re-presents it after the stall.
REQ-033 SHALL let flush win when flush and stall are both 1: redirect and bubble.
REQ-034 SHALL increment fetch_cnt by 1 on each edge that loads IF/ID with id_valid = 1, wrapping modulo 2^32.
REQ-035 SHALL not increment fetch_cnt on stall, flush or reset.
REQ-036 SHALL drive id_adel with ID responsible for raising AdEL, using id_pc as the BadVAddr.

Reset
REQ-037 SHALL, while rst = 1 at an edge, set pc = RESET_PC, ce_q = 0, id_pc = 0, id_inst = 0, id_valid = 0, id_adel = 0 and fetch_cnt = 0.
REQ-038 SHALL give rst priority over flush, stall and branch_flag.
REQ-039 SHALL apply the same reset values when reset is asserted mid-stream, with the first fetch at RESET_PC one cycle after rst deasserts.
REQ-040 SHALL keep rom_ce = 0 for the first cycle after rst deasserts, with pc held at RESET_PC.

Verification
REQ-041 SHALL cover sequential fetch: ROM words 0..3 = 34010000, 34021234, AC220000, 34025678; release reset -> id_pc 0,4,8,C with matching id_inst on consecutive cycles; fetch_cnt = 4.
REQ-042 SHALL cover stall: stall = 1 for 2 cycles while id_pc = 8 -> id_pc/id_inst held at 8 / AC220000; rom_addr held at C; fetch_cnt unchanged; resume at C.
REQ-043 SHALL cover branch with delay slot: branch_flag = 1, branch_target = 0x50 while pc = 0x14 -> id_pc 0x14 (delay slot), then 0x50.
REQ-044 SHALL cover flush over stall: flush = stall = 1, new_pc = 0x40 -> next id_valid = 0 and id_inst = 0; pc = 0x40; the following id_pc = 0x40.
REQ-045 SHALL cover misaligned redirect: flush with new_pc = 0x42 -> rom_ce = 0; next id_adel = 1, id_inst = 0, id_pc = 0x42.
REQ-046 SHALL cover reset mid-run and wrap: rst at fetch_cnt = 7 -> all outputs 0; RESET_PC = 32'hFFFFFFFC -> id_pc FFFFFFFC then 00000000.
